// File: rtl/lcd_frame_sequencer.sv
// lcd_frame_sequencer: SDRAM burst fetch into a FIFO streamed onto an 8080 LCD bus; LCD_CMD_PREFIX_EN adds a 16'h002C command word first
module lcd_frame_sequencer #(
  parameter int ADDR_W  = 32,
  parameter int CNT_W   = 20,
  parameter int BURST   = 8,
  parameter int FIFO_D  = 16,
  parameter int WR_LOW  = 2,
  parameter int WR_HIGH = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  pix_count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic [6:0]        avm_burstcount,
  input  logic              avm_waitrequest,
  input  logic [15:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  output logic              lcd_d_c_n,
  output logic              lcd_wr_n,
  output logic [15:0]       lcd_data
);
  localparam int AW = $clog2(FIFO_D);
  localparam int P  = WR_LOW + WR_HIGH;
  localparam int TW = $clog2(P + 1);
`ifdef LCD_CMD_PREFIX_EN
  typedef enum logic [1:0] {IDLE, CMD, FETCH, DRAIN} state_t;
  localparam state_t FIRST = CMD;
`else
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  localparam state_t FIRST = FETCH;
`endif
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [6:0]        out_q, out_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_q, rd_d;
  logic [ADDR_W-1:0] ad_q, ad_d;
  logic [6:0]        bc_q, bc_d;
  logic [15:0]       mem [FIFO_D];
  logic [AW-1:0]     wp_q, wp_d;
  logic [AW-1:0]     rp_q, rp_d;
  logic [AW:0]       fc_q, fc_d;
  logic              wr_n_q, wr_n_d;
  logic [15:0]       dat_q, dat_d;
  logic              act_q, act_d;
  logic [TW-1:0]     t_q, t_d;
  logic [6:0]        len;
  logic              accept;
  logic              push;
  logic              pop;
  logic              wend;
  logic              issue;
  logic              launch;
  assign accept = rd_q && !avm_waitrequest;
  assign push   = avm_readdatavalid && out_q != 7'd0;
  assign wend   = act_q && t_q == TW'(P - 1);
  assign pop    = (state_q == FETCH || state_q == DRAIN) && fc_q != '0 && (!act_q || wend);
  assign len    = rem_q < CNT_W'(BURST) ? 7'(rem_q) : 7'(BURST);
  assign issue  = state_q == FETCH && !rd_q && out_q == 7'd0 && rem_q != '0 &&
                  (FIFO_D - int'(fc_q)) >= int'(len);
`ifdef LCD_CMD_PREFIX_EN
  logic cmd_q, cmd_d;
  logic dc_q, dc_d;
  assign launch = state_q == CMD && !act_q && !cmd_q;
  // Command word bookkeeping: sent once per frame, d_c_n follows the word on the bus
  always_comb begin
    cmd_d = launch ? 1'b1 : state_q == IDLE ? 1'b0 : cmd_q;
    dc_d  = pop ? 1'b1 : launch ? 1'b0 : dc_q;
  end
  // Command state registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cmd_q <= 1'b0;
      dc_q  <= 1'b1;
    end else begin
      cmd_q <= cmd_d;
      dc_q  <= dc_d;
    end
  end
  assign lcd_d_c_n = dc_q;
`else
  assign launch    = 1'b0;
  assign lcd_d_c_n = 1'b1;
`endif
  // Frame FSM and burst requester; a burst only issues when its whole length fits in the FIFO
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    addr_d  = addr_q;
    rem_d   = rem_q;
    rd_d    = issue ? 1'b1 : accept ? 1'b0 : rd_q;
    ad_d    = issue ? addr_q : ad_q;
    bc_d    = issue ? len : bc_q;
    out_d   = out_q + (accept ? bc_q : 7'd0) - 7'(push);
    if (accept) begin
      addr_d = addr_q + ADDR_W'({bc_q, 1'b0});
      rem_d  = rem_q > CNT_W'(bc_q) ? rem_q - CNT_W'(bc_q) : '0;
    end
    case (state_q)
      IDLE: if (start) begin
        done_d = pix_count == '0;
        if (pix_count != '0) begin
          busy_d  = 1'b1;
          addr_d  = base_addr;
          rem_d   = pix_count;
          state_d = FIRST;
        end
      end
`ifdef LCD_CMD_PREFIX_EN
      CMD: if (cmd_q && wend) state_d = FETCH;
`endif
      FETCH: if (rem_q == '0 && out_q == 7'd0 && !rd_q) state_d = DRAIN;
      DRAIN: if (fc_q == '0 && (!act_q || wend)) begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // LCD writer: wr_n low for WR_LOW cycles then high for WR_HIGH, data held for the whole period
  always_comb begin
    wr_n_d = wr_n_q;
    dat_d  = dat_q;
    act_d  = act_q;
    t_d    = t_q;
    if (act_q) begin
      t_d    = t_q + TW'(1);
      wr_n_d = t_q == TW'(WR_LOW - 1) ? 1'b1 : wr_n_q;
      act_d  = !wend;
    end
    if (pop || launch) begin
      act_d  = 1'b1;
      t_d    = '0;
      wr_n_d = 1'b0;
      dat_d  = pop ? mem[rp_q] : 16'h002C;
    end
  end
  // FIFO pointers and occupancy
  always_comb begin
    wp_d = wp_q + AW'(push);
    rp_d = rp_q + AW'(pop);
    fc_d = fc_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  // State registers; reset abandons any frame in flight
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_q    <= 1'b0;
      ad_q    <= '0;
      bc_q    <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      fc_q    <= '0;
      wr_n_q  <= 1'b1;
      dat_q   <= '0;
      act_q   <= 1'b0;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_q    <= rd_d;
      ad_q    <= ad_d;
      bc_q    <= bc_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      fc_q    <= fc_d;
      wr_n_q  <= wr_n_d;
      dat_q   <= dat_d;
      act_q   <= act_d;
      t_q     <= t_d;
    end
  end
  // FIFO storage, emptied by pointer reset
  always_ff @(posedge clk) begin
    if (push) mem[wp_q] <= avm_readdata;
  end
  assign busy           = busy_q;
  assign done           = done_q;
  assign avm_address    = ad_q;
  assign avm_read       = rd_q;
  assign avm_burstcount = bc_q;
  assign lcd_wr_n       = wr_n_q;
  assign lcd_data       = dat_q;
endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// tb_lcd_frame_sequencer: directed frames against an Avalon burst slave model and an LCD bus monitor
module tb_lcd_frame_sequencer;
  localparam int FIFO_D  = 16;
  localparam int WR_LOW  = 2;
  localparam int WR_HIGH = 2;
`ifdef LCD_CMD_PREFIX_EN
  localparam int OFF = 1;
`else
  localparam int OFF = 0;
`endif
  logic        clk = 0, reset_n = 0, start = 0;
  logic [31:0] base_addr = 0;
  logic [19:0] pix_count = 0;
  logic        avm_waitrequest = 0, avm_readdatavalid = 0;
  logic [15:0] avm_readdata = 0;
  logic        busy, done, avm_read, lcd_d_c_n, lcd_wr_n;
  logic [31:0] avm_address;
  logic [6:0]  avm_burstcount;
  logic [15:0] lcd_data;
  int n_chk = 0, n_err = 0, cyc = 0;
  logic [15:0] r_data [512];
  logic        r_dc [512];
  int r_cyc [512], f_cyc [512];
  int n_rise = 0, n_low = 0, n_rdc = 0, n_done = 0, done_cyc = 0;
  int hold_bad = 0, stall_bad = 0, n_stall = 0, fmax = 0;
  logic [31:0] ba [64];
  int bl [64], bcyc [64];
  int nb = 0;
  int stall_b = -1;
  bit gap = 0;
  lcd_frame_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr), .pix_count(pix_count),
    .busy(busy), .done(done), .avm_address(avm_address), .avm_read(avm_read),
    .avm_burstcount(avm_burstcount), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .lcd_d_c_n(lcd_d_c_n), .lcd_wr_n(lcd_wr_n), .lcd_data(lcd_data)
  );
  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end
  assert property (@(posedge clk) disable iff (!reset_n)
    !(dut.push && !dut.pop && int'(dut.fc_q) == FIFO_D));
  function automatic logic [15:0] pix(input logic [31:0] a);
    return a[16:1] ^ 16'h5A00;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Avalon slave model and LCD monitor, sampled on the falling edge
  initial begin
    bit prev_wr, req_seen, gph;
    logic [15:0] fall_data;
    logic [31:0] req_a;
    logic [6:0]  req_l;
    logic [31:0] q [$];
    int stall_used;
    prev_wr = 1; req_seen = 0; gph = 0; fall_data = 0; req_a = 0; req_l = 0; stall_used = 0;
    forever begin
      @(negedge clk);
      if (int'(dut.fc_q) > fmax) fmax = int'(dut.fc_q);
      if (!reset_n) begin
        q.delete();
        avm_waitrequest = 0;
        avm_readdatavalid = 0;
        req_seen = 0;
        stall_used = 0;
        prev_wr = lcd_wr_n;
      end else begin
        gph = !gph;
        if (q.size() > 0 && (!gap || gph)) begin
          avm_readdatavalid = 1;
          avm_readdata = pix(q.pop_front());
        end else avm_readdatavalid = 0;
        if (avm_read) begin
          n_rdc++;
          if (!req_seen) begin
            req_seen = 1; req_a = avm_address; req_l = avm_burstcount;
            if (nb < 64) bcyc[nb] = cyc;
          end
          if (avm_address !== req_a || avm_burstcount !== req_l) stall_bad++;
          if (nb == stall_b && stall_used < 5) begin
            avm_waitrequest = 1; stall_used++; n_stall++;
          end else begin
            avm_waitrequest = 0;
            if (nb < 64) begin ba[nb] = avm_address; bl[nb] = int'(avm_burstcount); end
            for (int i = 0; i < int'(avm_burstcount); i++) q.push_back(avm_address + 32'(2 * i));
            nb++; req_seen = 0; stall_used = 0;
          end
        end else avm_waitrequest = 0;
        if (prev_wr && !lcd_wr_n) begin
          fall_data = lcd_data;
          if (n_rise < 512) f_cyc[n_rise] = cyc;
        end
        if (!lcd_wr_n) begin
          n_low++;
          if (lcd_data !== fall_data) hold_bad++;
        end
        if (!prev_wr && lcd_wr_n && n_rise < 512) begin
          r_data[n_rise] = lcd_data; r_dc[n_rise] = lcd_d_c_n; r_cyc[n_rise] = cyc; n_rise++;
        end
        prev_wr = lcd_wr_n;
        if (done) begin n_done++; done_cyc = cyc; end
      end
    end
  end
  task automatic chk_reset();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_read", 32'(avm_read), 0);
    check("rst_addr", avm_address, 0);
    check("rst_bcnt", 32'(avm_burstcount), 0);
    check("rst_wr_n", 32'(lcd_wr_n), 1);
    check("rst_dcn", 32'(lcd_d_c_n), 1);
    check("rst_data", 32'(lcd_data), 0);
  endtask
  task automatic frame(input logic [31:0] b, input int cnt, input bit gp, input bit stl, input bit per);
    int r0, b0, d0, s0, k, nbx, ln;
    bit ok;
    gap = gp; stall_b = stl ? nb + 1 : -1;
    r0 = n_rise; b0 = nb; d0 = n_done; s0 = n_stall;
    @(posedge clk); #1;
    base_addr = b; pix_count = 20'(cnt); start = 1;
    @(posedge clk); #1;
    start = 0;
    check("busy_rise", 32'(busy), 1);
    ok = 0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      @(posedge clk); #1;
      if (done) ok = 1;
    end
    check("done_seen", 32'(ok), 1);
    check("busy_at_done", 32'(busy), 0);
    @(negedge clk); #1;
    check("done_cnt", n_done - d0, 1);
    check("pulses", n_rise - r0, cnt + OFF);
`ifdef LCD_CMD_PREFIX_EN
    check("cmd_dcn", 32'(r_dc[r0]), 0);
    check("cmd_data", 32'(r_data[r0]), 32'h002C);
    check("cmd_first", 32'(r_cyc[r0] < bcyc[b0]), 1);
`endif
    for (int i = 0; i < cnt && r0 + OFF + i < n_rise; i++) begin
      k = r0 + OFF + i;
      check("pix", 32'(r_data[k]), 32'(pix(b + 32'(2 * i))));
      check("dcn", 32'(r_dc[k]), 1);
      check("low_w", r_cyc[k] - f_cyc[k], WR_LOW);
      if (per && i > 0) check("period", f_cyc[k] - f_cyc[k-1], WR_LOW + WR_HIGH);
    end
    if (n_rise > r0) check("done_lat", done_cyc - r_cyc[n_rise-1], WR_HIGH);
    nbx = (cnt + 7) / 8;
    check("bursts", nb - b0, nbx);
    for (int j = 0; j < nbx && b0 + j < nb; j++) begin
      ln = cnt - 8 * j < 8 ? cnt - 8 * j : 8;
      check("b_addr", ba[b0+j], b + 32'(16 * j));
      check("b_len", bl[b0+j], ln);
    end
    check("hold", hold_bad, 0);
    check("stall_stable", stall_bad, 0);
    check("fifo_max", 32'(fmax <= FIFO_D), 1);
    if (stl) check("stall_cyc", n_stall - s0, 5);
    repeat (3) @(posedge clk);
  endtask
  initial begin
    int r0, c0, l0, d0, zb;
    bit ok;
    repeat (3) @(posedge clk);
    #1;
    chk_reset();
    reset_n = 1;
    repeat (2) @(posedge clk);
    frame(32'h1000, 8, 0, 0, 1);
    frame(32'h2000, 21, 0, 0, 0);
    frame(32'h4000, 21, 1, 1, 0);
    r0 = n_rise; c0 = n_rdc; l0 = n_low; d0 = n_done; zb = 0;
    @(posedge clk); #1;
    pix_count = 0; start = 1;
    @(posedge clk); #1;
    start = 0;
    check("z_done", 32'(done), 1);
    check("z_busy", 32'(busy), 0);
    @(posedge clk); #1;
    check("z_done_once", 32'(done), 0);
    repeat (20) begin
      @(posedge clk); #1;
      if (busy) zb++;
    end
    check("z_busy_never", zb, 0);
    check("z_read", n_rdc - c0, 0);
    check("z_wr_low", n_low - l0, 0);
    check("z_rise", n_rise - r0, 0);
    check("z_done_total", n_done - d0, 1);
    r0 = n_rise; ok = 0;
    @(posedge clk); #1;
    base_addr = 32'h3000; pix_count = 20'd40; start = 1;
    @(posedge clk); #1;
    start = 0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(posedge clk); #1;
      if (n_rise - r0 >= 5 + OFF) ok = 1;
    end
    check("mid_reached", 32'(ok), 1);
    reset_n = 0;
    @(posedge clk); #1;
    chk_reset();
    @(posedge clk); #1;
    reset_n = 1;
    d0 = n_done;
    repeat (10) @(posedge clk);
    #1;
    check("mid_no_done", n_done - d0, 0);
    check("mid_idle", 32'(busy), 0);
    frame(32'h3100, 4, 0, 0, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
